// File: rtl/dsi_lanes_controller_mp.sv
// DSI lane controller, parametrised lane count.
// Sequences the LP buffer enables and clock-lane start/stop for up to LANES
// data lanes, and stripes host words across the active lanes one byte per
// lane. Partial last words, data underflow, lane skew and clock-lane
// start/stop timeouts are handled here.
module dsi_lanes_controller_mp #(
  parameter int LANES       = 4,
  parameter int CLK_TIMEOUT = 1024,
  parameter int LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic [LW-1:0]      reg_lanes_number,
  input  logic               lines_enable,
  input  logic               clock_enable,
  input  logic [LANES*8-1:0] iface_write_data,
  input  logic [LANES-1:0]   iface_write_strb,
  input  logic               iface_write_rqst,
  input  logic               iface_last_word,
  output logic               iface_data_rqst,
  output logic [LANES-1:0]   lane_start_rqst,
  output logic [LANES-1:0]   lane_fin_rqst,
  output logic [LANES*8-1:0] lane_data,
  input  logic [LANES-1:0]   lane_data_rqst,
  input  logic [LANES-1:0]   lane_active,
  output logic [LANES-1:0]   lane_lines_enable,
  output logic               clk_start_rqst,
  output logic               clk_fin_rqst,
  input  logic               clk_active,
  output logic               lines_ready,
  output logic               clock_ready,
  output logic               tx_active,
  output logic               data_underflow_error,
  output logic               clk_timeout_error
);

  localparam int CW = $clog2(CLK_TIMEOUT + 1);
  // Counter value seen in the CLK_TIMEOUT-th cycle spent in a WAIT state.
  localparam logic [CW-1:0] TO_LAST = CW'(CLK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    P_IDLE         = 3'd0,
    P_EN_BUF       = 3'd1,
    P_WAIT_CLK_ON  = 3'd2,
    P_ACTIVE       = 3'd3,
    P_WAIT_CLK_OFF = 3'd4,
    P_DIS_BUF      = 3'd5
  } pwr_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_LAST = 2'd2,
    T_FIN  = 2'd3
  } tx_state_t;

  // Lowest (n+1) lanes set; n saturates at LANES-1.
  function automatic logic [LANES-1:0] lane_mask(input logic [LW-1:0] num);
    logic [LANES-1:0] m;
    int               n;
    m = {LANES{1'b0}};
    n = (int'(num) >= LANES) ? (LANES - 1) : int'(num);
    for (int i = 0; i < LANES; i++) begin
      m[i] = (i <= n);
    end
    return m;
  endfunction

  pwr_state_t         pwr_state_r, pwr_next_s;
  tx_state_t          tx_state_r, tx_next_s;
  logic [CW-1:0]      to_cnt_r;
  logic               to_expired_s;
  logic               timeout_set_s;
  logic [LANES-1:0]   mask_r;
  logic [LANES-1:0]   lines_en_r;
  logic               clk_err_r;
  logic               uf_err_r;
  logic               lines_ready_s;
  logic               accept_s;
  logic               load_s;
  logic               underflow_s;
  logic               skew_s;
  logic [LANES*8-1:0] byte_mask_s;
  logic [LANES*8-1:0] data_r;
  logic [LANES-1:0]   strb_r;
  logic               last_r;
  logic [LANES-1:0]   start_r;
  logic [LANES-1:0]   fin_r;
  logic               pop_r;
  logic               tx_active_r;

  assign lines_ready_s = (pwr_state_r == P_ACTIVE);
  assign to_expired_s  = (to_cnt_r == TO_LAST);

  // Power FSM next state; shutdown waits for any burst to finish.
  always_comb begin
    pwr_next_s    = pwr_state_r;
    timeout_set_s = 1'b0;
    case (pwr_state_r)
      P_IDLE: begin
        if (lines_enable) pwr_next_s = P_EN_BUF;
        else              pwr_next_s = P_IDLE;
      end
      P_EN_BUF: begin
        if (clock_enable) pwr_next_s = P_WAIT_CLK_ON;
        else              pwr_next_s = P_EN_BUF;
      end
      P_WAIT_CLK_ON: begin
        if (clk_active) begin
          pwr_next_s = P_ACTIVE;
        end else if (to_expired_s) begin
          pwr_next_s    = P_WAIT_CLK_OFF;
          timeout_set_s = 1'b1;
        end else begin
          pwr_next_s = P_WAIT_CLK_ON;
        end
      end
      P_ACTIVE: begin
        // A burst starting this very cycle also holds the clock on.
        if (!clock_enable && !tx_active_r && !accept_s) pwr_next_s = P_WAIT_CLK_OFF;
        else                                             pwr_next_s = P_ACTIVE;
      end
      P_WAIT_CLK_OFF: begin
        if (!clk_active) begin
          pwr_next_s = P_DIS_BUF;
        end else if (clock_enable) begin
          pwr_next_s = P_WAIT_CLK_ON;
        end else if (to_expired_s) begin
          pwr_next_s    = P_DIS_BUF;
          timeout_set_s = 1'b1;
        end else begin
          pwr_next_s = P_WAIT_CLK_OFF;
        end
      end
      P_DIS_BUF: begin
        if (!lines_enable) pwr_next_s = P_IDLE;
        else               pwr_next_s = P_DIS_BUF;
      end
      default: pwr_next_s = P_IDLE;
    endcase
  end

  // Power FSM state register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) pwr_state_r <= P_IDLE;
    else     pwr_state_r <= pwr_next_s;
  end

  // Timeout counter: zero on entry to a WAIT state, counts while waiting.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      to_cnt_r <= {CW{1'b0}};
    end else if (((pwr_next_s == P_WAIT_CLK_ON) || (pwr_next_s == P_WAIT_CLK_OFF)) &&
                 (pwr_next_s != pwr_state_r)) begin
      to_cnt_r <= {CW{1'b0}};
    end else if ((pwr_state_r == P_WAIT_CLK_ON) || (pwr_state_r == P_WAIT_CLK_OFF)) begin
      to_cnt_r <= to_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_r <= {CW{1'b0}};
    end
  end

  // Lane mask latched on entering EN_BUF; buffers dropped on entering DIS_BUF.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      mask_r     <= {LANES{1'b0}};
      lines_en_r <= {LANES{1'b0}};
    end else if ((pwr_state_r == P_IDLE) && (pwr_next_s == P_EN_BUF)) begin
      mask_r     <= lane_mask(reg_lanes_number);
      lines_en_r <= lane_mask(reg_lanes_number);
    end else if (pwr_next_s == P_DIS_BUF) begin
      lines_en_r <= {LANES{1'b0}};
    end else begin
      lines_en_r <= lines_en_r;
    end
  end

  // Sticky clock timeout flag, cleared only while idle.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)                          clk_err_r <= 1'b0;
    else if (pwr_state_r == P_IDLE)   clk_err_r <= 1'b0;
    else if (timeout_set_s)           clk_err_r <= 1'b1;
    else                              clk_err_r <= clk_err_r;
  end

  // Byte-enable for the masked lanes so unmasked lanes always carry zero.
  always_comb begin
    byte_mask_s = {(LANES*8){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      byte_mask_s[i*8 +: 8] = {8{mask_r[i]}};
    end
  end

  // TX FSM next state; lane 0 paces the burst.
  always_comb begin
    tx_next_s   = tx_state_r;
    accept_s    = 1'b0;
    load_s      = 1'b0;
    underflow_s = 1'b0;
    skew_s      = (tx_state_r == T_RUN) &&
                  (((lane_data_rqst ^ {LANES{lane_data_rqst[0]}}) & mask_r) != {LANES{1'b0}});
    case (tx_state_r)
      T_IDLE: begin
        if (lines_ready_s && iface_write_rqst) begin
          accept_s  = 1'b1;
          tx_next_s = T_RUN;
        end else begin
          tx_next_s = T_IDLE;
        end
      end
      T_RUN: begin
        if (lane_data_rqst[0]) begin
          if (last_r) begin
            tx_next_s = T_LAST;
          end else if (iface_write_rqst) begin
            load_s    = 1'b1;
            tx_next_s = T_RUN;
          end else begin
            underflow_s = 1'b1;
            tx_next_s   = T_FIN;
          end
        end else begin
          tx_next_s = T_RUN;
        end
      end
      T_LAST: begin
        if (lane_data_rqst[0]) tx_next_s = T_FIN;
        else                   tx_next_s = T_LAST;
      end
      T_FIN: begin
        if ((lane_active & mask_r) == {LANES{1'b0}}) tx_next_s = T_IDLE;
        else                                         tx_next_s = T_FIN;
      end
      default: tx_next_s = T_IDLE;
    endcase
  end

  // TX FSM state and burst-activity register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      tx_state_r  <= T_IDLE;
      tx_active_r <= 1'b0;
    end else begin
      tx_state_r  <= tx_next_s;
      tx_active_r <= (tx_next_s != T_IDLE);
    end
  end

  // Word holding register plus one-cycle start and pop pulses.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      data_r  <= {(LANES*8){1'b0}};
      strb_r  <= {LANES{1'b0}};
      last_r  <= 1'b0;
      start_r <= {LANES{1'b0}};
      pop_r   <= 1'b0;
    end else begin
      start_r <= accept_s ? mask_r : {LANES{1'b0}};
      pop_r   <= accept_s | load_s;
      if (accept_s | load_s) begin
        data_r <= iface_write_data & byte_mask_s;
        strb_r <= iface_write_strb & mask_r;
        last_r <= iface_last_word;
      end else begin
        data_r <= data_r;
        strb_r <= strb_r;
        last_r <= last_r;
      end
    end
  end

  // Finish requests: partial lanes first, then all lanes until they go quiet;
  // cleared one cycle after the FSM is back in T_IDLE.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      fin_r <= {LANES{1'b0}};
    end else if (tx_state_r == T_IDLE) begin
      fin_r <= {LANES{1'b0}};
    end else if ((tx_state_r == T_RUN) && (tx_next_s == T_LAST)) begin
      fin_r <= mask_r & ~strb_r;
    end else if (tx_next_s == T_FIN) begin
      fin_r <= mask_r;
    end else begin
      fin_r <= fin_r;
    end
  end

  // Sticky underflow / lane-skew flag, cleared only while powered down.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)                         uf_err_r <= 1'b0;
    else if (pwr_state_r == P_IDLE)  uf_err_r <= 1'b0;
    else if (underflow_s || skew_s)  uf_err_r <= 1'b1;
    else                             uf_err_r <= uf_err_r;
  end

  assign iface_data_rqst      = pop_r;
  assign lane_start_rqst      = start_r;
  assign lane_fin_rqst        = fin_r;
  assign lane_data            = data_r;
  assign lane_lines_enable    = lines_en_r;
  assign clk_start_rqst       = (pwr_next_s == P_WAIT_CLK_ON);
  assign clk_fin_rqst         = (pwr_next_s == P_WAIT_CLK_OFF);
  assign lines_ready          = lines_ready_s;
  assign clock_ready          = clk_active;
  assign tx_active            = tx_active_r;
  assign data_underflow_error = uf_err_r;
  assign clk_timeout_error    = clk_err_r;

endmodule

// File: tb/tb_dsi_lanes_controller_mp.sv
// Directed bench for dsi_lanes_controller_mp: a power-FSM vector table plus
// hand-written burst, underflow, timeout, skew and async-reset sequences.
module tb_dsi_lanes_controller_mp;

  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  // 4-lane instance, short timeout
  logic [1:0]  rln;
  logic        le, ce, ca, wrq, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb, ldr, lact;
  logic        drq, cstart, cfin, lready, cready, txa, uerr, terr;
  logic [3:0]  lstart, lfin, lle;
  logic [31:0] ldata;

  dsi_lanes_controller_mp #(.LANES(4), .CLK_TIMEOUT(16)) u_dut (
    .clk_sys(clk_sys), .rst(rst), .reg_lanes_number(rln),
    .lines_enable(le), .clock_enable(ce),
    .iface_write_data(wdata), .iface_write_strb(wstrb),
    .iface_write_rqst(wrq), .iface_last_word(wlast),
    .iface_data_rqst(drq), .lane_start_rqst(lstart), .lane_fin_rqst(lfin),
    .lane_data(ldata), .lane_data_rqst(ldr), .lane_active(lact),
    .lane_lines_enable(lle), .clk_start_rqst(cstart), .clk_fin_rqst(cfin),
    .clk_active(ca), .lines_ready(lready), .clock_ready(cready),
    .tx_active(txa), .data_underflow_error(uerr), .clk_timeout_error(terr)
  );

  // 8-lane instance
  logic [2:0]  rln8;
  logic        le8, ce8, ca8, wrq8, wlast8;
  logic [63:0] wdata8, ldata8;
  logic [7:0]  wstrb8, ldr8, lact8, lstart8, lfin8, lle8;
  logic        drq8, cstart8, cfin8, lready8, cready8, txa8, uerr8, terr8;

  dsi_lanes_controller_mp #(.LANES(8)) u_dut8 (
    .clk_sys(clk_sys), .rst(rst), .reg_lanes_number(rln8),
    .lines_enable(le8), .clock_enable(ce8),
    .iface_write_data(wdata8), .iface_write_strb(wstrb8),
    .iface_write_rqst(wrq8), .iface_last_word(wlast8),
    .iface_data_rqst(drq8), .lane_start_rqst(lstart8), .lane_fin_rqst(lfin8),
    .lane_data(ldata8), .lane_data_rqst(ldr8), .lane_active(lact8),
    .lane_lines_enable(lle8), .clk_start_rqst(cstart8), .clk_fin_rqst(cfin8),
    .clk_active(ca8), .lines_ready(lready8), .clock_ready(cready8),
    .tx_active(txa8), .data_underflow_error(uerr8), .clk_timeout_error(terr8)
  );

  typedef struct {
    logic       le, ce, ca;
    logic [1:0] rln;
    logic [3:0] lle;
    logic       st, fn, rdy;
  } pvec_t;

  pvec_t vt[15];
  int    n_pass  = 0;
  int    n_total = 0;
  int    drq_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    if (drq === 1'b1) drq_cnt++;
  endtask

  initial begin
    logic ok;
    int   rises;
    logic prev;

    // le ce ca rln | lane_lines_enable clk_start clk_fin lines_ready
    vt[0]  = '{1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 2'd3, 4'b0011, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 2'd1, 4'b0011, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 2'd1, 4'b0011, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0011, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0011, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 2'd3, 4'b1111, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b0, 2'd3, 4'b1111, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    rln = 2'd0; le = 1'b0; ce = 1'b0; ca = 1'b0; wrq = 1'b0; wlast = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; ldr = 4'h0; lact = 4'h0;
    rln8 = 3'd0; le8 = 1'b0; ce8 = 1'b0; ca8 = 1'b0; wrq8 = 1'b0; wlast8 = 1'b0;
    wdata8 = 64'h0; wstrb8 = 8'h0; ldr8 = 8'h0; lact8 = 8'h0;

    repeat (2) @(posedge clk_sys);
    #1;
    chk("reset_outputs", {lstart, lfin, ldata, lle, drq, cstart, cfin, lready, txa, uerr, terr}, 64'h0);
    #3 rst = 1'b0;

    // Power FSM table
    for (int i = 0; i < 15; i++) begin
      le = vt[i].le; ce = vt[i].ce; ca = vt[i].ca; rln = vt[i].rln;
      step();
      chk($sformatf("pwr_vec%0d", i), {lle, cstart, cfin, lready},
          {vt[i].lle, vt[i].st, vt[i].fn, vt[i].rdy});
    end

    // Clock never comes up: timeout after 16 cycles in WAIT_CLK_ON
    ok = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (!(cstart === 1'b1 && cfin === 1'b0 && terr === 1'b0)) ok = 1'b0;
    end
    chk("timeout_wait_window", ok, 1'b1);
    step(); chk("timeout_fin_rqst", {cstart, cfin, terr}, 3'b010);
    step(); chk("timeout_err_set", {terr, cfin, lle}, {1'b1, 1'b0, 4'b1111});
    step(); chk("timeout_dis_buf", {terr, lle}, {1'b1, 4'b0000});
    le = 1'b0;
    step(); chk("timeout_err_entering_idle", terr, 1'b1);
    step(); chk("timeout_err_cleared", terr, 1'b0);

    // Bring-up with 2 lanes, clock arrives after 10 cycles
    rln = 2'd1; le = 1'b1;
    step(); chk("bringup_lines_enable", lle, 4'b0011);
    ce = 1'b1; ok = 1'b1; rises = 0; prev = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (cstart === 1'b1 && prev === 1'b0) rises++;
      prev = cstart;
      if (lready !== 1'b0) ok = 1'b0;
    end
    chk("bringup_start_window", {rises[7:0], ok}, {8'd1, 1'b1});
    ca = 1'b1;
    step(); chk("bringup_ready", {lready, cstart, cready}, 3'b101);

    // 3-word burst, last word partial, clock_enable dropped mid-burst
    lact = 4'b0011; drq_cnt = 0;
    wdata = 32'hDDCC_BBAA; wstrb = 4'b0011; wlast = 1'b0; wrq = 1'b1;
    step(); chk("burst_start", {lstart, drq, txa, ldata}, {4'b0011, 1'b1, 1'b1, 32'h0000_BBAA});
    wdata = 32'h4433_2211; ce = 1'b0;
    step(); chk("burst_start_pulse_end", {lstart, drq, cfin}, {4'b0000, 1'b0, 1'b0});
    ldr = 4'b0011;
    step(); chk("burst_word1", {ldata, drq, uerr}, {32'h0000_2211, 1'b1, 1'b0});
    ldr = 4'b0000; wdata = 32'h8877_6655; wlast = 1'b1; wstrb = 4'b0001;
    step();
    ldr = 4'b0011;
    step(); chk("burst_word2", {ldata, drq}, {32'h0000_6655, 1'b1});
    ldr = 4'b0000; wrq = 1'b0;
    step();
    ldr = 4'b0011;
    step(); chk("burst_last_partial_fin", {lfin, drq, txa}, {4'b0010, 1'b0, 1'b1});
    ldr = 4'b0000;
    step(); chk("burst_last_hold", lfin, 4'b0010);
    ldr = 4'b0011;
    step(); chk("burst_fin_all", {lfin, txa}, {4'b0011, 1'b1});
    ldr = 4'b0000;
    step(); chk("burst_fin_wait_lanes", {lfin, txa, cfin, lready}, {4'b0011, 1'b1, 1'b0, 1'b1});
    lact = 4'b0000;
    step(); chk("burst_done", {lfin, txa, cfin}, {4'b0011, 1'b0, 1'b1});
    step(); chk("burst_fin_cleared", {lfin, cfin, lready, uerr}, {4'b0000, 1'b1, 1'b0, 1'b0});
    chk("burst_pop_count", drq_cnt, 64'd3);
    ce = 1'b1;
    #1; chk("clk_restart_rqst", {cstart, cfin}, 2'b10);
    step(); chk("back_to_wait_on", {cfin, lready, lle}, {1'b0, 1'b0, 4'b0011});
    step(); chk("reactivated", lready, 1'b1);

    // Host drops the word stream mid-burst
    lact = 4'b0011; wdata = 32'h1234_5678; wstrb = 4'b0011; wlast = 1'b0; wrq = 1'b1;
    step(); chk("uf_accept", {txa, lstart}, {1'b1, 4'b0011});
    wrq = 1'b0;
    step();
    ldr = 4'b0011;
    step(); chk("uf_detect", {uerr, lfin, drq}, {1'b1, 4'b0011, 1'b0});
    ldr = 4'b0000; lact = 4'b0000;
    step(); chk("uf_back_idle", {txa, uerr, lfin}, {1'b0, 1'b1, 4'b0011});
    ce = 1'b0;
    step(); chk("uf_err_sticky_wait_off", {uerr, cfin}, 2'b11);
    ca = 1'b0;
    step(); chk("uf_err_sticky_dis_buf", {uerr, lle}, {1'b1, 4'b0000});
    le = 1'b0;
    step(); chk("uf_err_entering_idle", uerr, 1'b1);
    step(); chk("uf_err_cleared_idle", uerr, 1'b0);

    // 8 lanes: skew detection, then async reset mid-burst
    rln8 = 3'd7; le8 = 1'b1;
    step();
    ce8 = 1'b1;
    step();
    ca8 = 1'b1;
    step(); chk("l8_active", {lle8, lready8}, {8'hFF, 1'b1});
    lact8 = 8'hFF; wdata8 = 64'h0807_0605_0403_0201; wstrb8 = 8'hFF; wlast8 = 1'b0; wrq8 = 1'b1;
    step(); chk("l8_start", lstart8, 8'hFF);
    chk("l8_data", ldata8, 64'h0807_0605_0403_0201);
    ldr8 = 8'h01;
    step(); chk("l8_skew_err", {uerr8, drq8}, 2'b11);
    ldr8 = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("l8_async_reset_ctrl",
        {lstart8, lfin8, lle8, drq8, cstart8, cfin8, lready8, txa8, uerr8, terr8}, 64'h0);
    chk("l8_async_reset_data", ldata8, 64'h0);
    #3 rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dsi_lanes_controller_mp.md
Name: dsi_lanes_controller_mp

Overview:
Parametrised successor to the fixed 4-lane DSI lane controller. It sequences LP buffer enable and clock-lane start/stop for up to LANES data lanes, and stripes host words across the active lanes byte-per-lane. It handles partial last words and detects data underflow and clock-lane start timeout. It sits between the packet assembler and the per-lane dsi_lane_full instances plus the clock lane.

Parameters:
LANES, 4, number of physical data lanes (1..8)
CLK_TIMEOUT, 1024, clk_sys cycles allowed for clk_active to rise (or fall) after a request
LW, $clog2(LANES) (min 1), width of reg_lanes_number

Ports:
clk_sys  in  1  single system clock
rst  in  1  asynchronous, active-high reset
reg_lanes_number  in  LW  active lanes minus 1; values >= LANES saturate to LANES-1
lines_enable  in  1  request LP buffers on
clock_enable  in  1  request HS clock lane running
iface_write_data  in  LANES*8  byte i drives lane i
iface_write_strb  in  LANES  per-lane byte valid
iface_write_rqst  in  1  word available
iface_last_word  in  1  current word is final
iface_data_rqst  out  1  1-cycle pop of current word
lane_start_rqst  out  LANES  1-cycle start to each lane
lane_fin_rqst  out  LANES  per-lane finish request
lane_data  out  LANES*8  registered lane bytes
lane_data_rqst  in  LANES  per-lane byte consumed
lane_active  in  LANES  lane in HS transmission
lane_lines_enable  out  LANES  per-lane LP buffer enable
clk_start_rqst  out  1  clock-lane start
clk_fin_rqst  out  1  clock-lane stop
clk_active  in  1  clock lane running
lines_ready  out  1  power FSM in LANES_ACTIVE
clock_ready  out  1  equals clk_active
tx_active  out  1  HS burst in progress
data_underflow_error  out  1  sticky
clk_timeout_error  out  1  sticky

Behaviour:
- Reset: all outputs 0, both FSMs idle, errors cleared, mask = 0.
- Power FSM (registered state):
  - IDLE -> EN_BUF on lines_enable. Entering EN_BUF latches mask = lowest (sat(reg_lanes_number)+1) bits set, and lane_lines_enable <= mask.
  - EN_BUF -> WAIT_CLK_ON on clock_enable. clk_start_rqst is high combinationally while the next state is WAIT_CLK_ON.
  - WAIT_CLK_ON -> ACTIVE on clk_active.
  - ACTIVE -> WAIT_CLK_OFF when !clock_enable and !tx_active. Shutdown is deferred until any burst completes. clk_fin_rqst is high while the next state is WAIT_CLK_OFF.
  - WAIT_CLK_OFF -> DIS_BUF on !clk_active; -> WAIT_CLK_ON if clock_enable returns first.
  - DIS_BUF: lane_lines_enable <= 0; -> IDLE on !lines_enable.
- Timeout counter: reloads to 0 on entry to either WAIT state and increments each cycle.
  - At CLK_TIMEOUT in WAIT_CLK_ON: set clk_timeout_error and go to WAIT_CLK_OFF, issuing clk_fin_rqst.
  - At CLK_TIMEOUT in WAIT_CLK_OFF: set the error and go to DIS_BUF.
- Sticky errors clear only in IDLE or on rst.
- reg_lanes_number changes outside EN_BUF are ignored.
- TX FSM (T_IDLE, T_RUN, T_LAST, T_FIN):
  - T_IDLE: when lines_ready && iface_write_rqst:
    - pulse lane_start_rqst = mask for one cycle;
    - register lane_data = iface_write_data, last = iface_last_word, strb = iface_write_strb;
    - pulse iface_data_rqst;
    - tx_active = 1; -> T_RUN.
  - Lane 0 is the pacing lane. On lane_data_rqst[0] in T_RUN:
    - if the held word is last -> T_LAST;
    - else if iface_write_rqst: load the next word into lane_data the following cycle and pulse iface_data_rqst;
    - else set data_underflow_error and -> T_FIN.
  - T_LAST: lane_fin_rqst = mask & ~strb (partial word); lanes with strb = 1 send their byte. On the next lane_data_rqst[0], lane_fin_rqst = mask (held) -> T_FIN.
  - T_FIN: hold lane_fin_rqst = mask until (lane_active & mask) == 0, then -> T_IDLE, tx_active = 0. One cycle later, lane_fin_rqst = 0.
  - lane_data_rqst[i] != lane_data_rqst[0] for any masked lane i while in T_RUN: set data_underflow_error (lane skew); data flow continues.
  - Unmasked lanes: start, fin and data are always 0.
- Latency: iface_write_rqst to lane_start_rqst is 1 cycle; lane_data_rqst[0] to the next lane_data and iface_data_rqst is 1 cycle.
- Simultaneous events:
  - !lines_enable during ACTIVE is ignored until the clock stops.
  - iface_write_rqst in any state other than ACTIVE is not accepted.
  - rst mid-burst returns everything to reset values immediately.

Test Plan:
- LANES=4, reg_lanes_number=1, lines_enable then clock_enable, clk_active after 10 cycles -> lane_lines_enable=4'b0011, single clk_start_rqst window, lines_ready=1 on the cycle after clk_active.
- 3-word burst, 2 lanes, last strb=2'b01 -> lane_start_rqst=2'b11 once, 3 iface_data_rqst pulses, lane_fin_rqst[1] during T_LAST, then 2'b11 until lane_active=0; tx_active low afterwards.
- iface_write_rqst dropped mid-burst before lane_data_rqst[0] -> data_underflow_error=1 next cycle, lane_fin_rqst=mask, error cleared only after returning to IDLE.
- clk_active never rises, CLK_TIMEOUT=16 -> clk_timeout_error at cycle 16 of WAIT_CLK_ON, clk_fin_rqst asserted, FSM reaches DIS_BUF.
- clock_enable deasserted mid-burst -> clk_fin_rqst withheld until tx_active=0, then WAIT_CLK_OFF; reassert clock_enable before clk_active falls -> returns to WAIT_CLK_ON.
- LANES=8, reg_lanes_number=7, then rst=1 mid-burst -> all outputs 0 in the same cycle (async), mask=0.
